// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: opcodes, FSM state type and beat-offset helper for mem_responder
package mem_responder_pkg;
  localparam logic MEM_OP_RD = 1'b0;
  localparam logic MEM_OP_WR = 1'b1;
  typedef enum logic [1:0] {IDLE, READ, WRITE} mem_resp_state_t;
  function automatic int off_bits(input int data_bits);
    return $clog2(data_bits / 8);
  endfunction
endpackage

// File: rtl/mem_resp_fifo.sv
// mem_resp_fifo: 2-entry read-beat buffer with push/pop and occupancy count
module mem_resp_fifo #(
  parameter int W = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  always_ff @(posedge clock) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) mem[wr_ptr] <= push_data;
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count  <= count + 2'(push) - 2'(pop);
    end
  end
  assign head = mem[rd_ptr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: RAM-backed responder serving read/write bursts on the accelerator memory interface
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 64,
  parameter int MEM_DATA_BITS = 64,
  parameter int DEPTH_LOG2    = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mem_req_valid,
  input  logic                     mem_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]  mem_req_len,
  input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  input  logic                     mem_wr_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_wr_bits,
  output logic                     mem_rd_valid,
  output logic [MEM_DATA_BITS-1:0] mem_rd_bits,
  input  logic                     mem_rd_ready,
  output logic                     busy,
  output logic                     proto_err
);
  localparam int OFF = off_bits(MEM_DATA_BITS);
  localparam int LW  = MEM_LEN_BITS + 1;
  mem_resp_state_t          state, state_n;
  logic [DEPTH_LOG2-1:0]    idx, idx_n;
  logic [LW-1:0]            remaining, rem_n;
  logic [MEM_DATA_BITS-1:0] ram [2**DEPTH_LOG2];
  logic [MEM_DATA_BITS-1:0] rd_data;
  logic [MEM_DATA_BITS-1:0] fifo_head;
  logic [1:0]               count;
  logic [2:0]               occ_n;
  logic                     inflight, issue, take, fifo_push, fifo_pop, done, we;
  logic                     unused_addr;
  assign unused_addr = ^{mem_req_addr[MEM_ADDR_BITS-1:OFF+DEPTH_LOG2], mem_req_addr[OFF-1:0]};
  // A returning read bypasses the empty FIFO so the first beat appears two cycles after the request.
  assign issue        = state == READ && remaining != '0 && ({1'b0, count} + 3'(inflight)) < 3'd2;
  assign mem_rd_valid = count != '0 || inflight;
  assign mem_rd_bits  = count != '0 ? fifo_head : rd_data;
  assign take         = mem_rd_valid && mem_rd_ready;
  assign fifo_pop     = take && count != '0;
  assign fifo_push    = inflight && !(take && count == '0);
  assign occ_n        = {1'b0, count} + 3'(inflight) - 3'(take);
  assign done         = remaining == '0 && occ_n == '0;
  assign we           = state == WRITE && mem_wr_valid;
  assign busy         = state != IDLE;
  always_comb begin
    state_n = state;
    idx_n   = idx;
    rem_n   = remaining;
    case (state)
      IDLE: if (mem_req_valid) begin
        idx_n   = mem_req_addr[OFF +: DEPTH_LOG2];
        rem_n   = {1'b0, mem_req_len} + LW'(1);
        state_n = mem_req_opcode == MEM_OP_WR ? WRITE : READ;
      end
      WRITE: if (mem_wr_valid) begin
        idx_n   = idx + DEPTH_LOG2'(1);
        rem_n   = remaining - LW'(1);
        state_n = remaining == LW'(1) ? IDLE : WRITE;
      end
      READ: begin
        idx_n   = issue ? idx + DEPTH_LOG2'(1) : idx;
        rem_n   = issue ? remaining - LW'(1) : remaining;
        state_n = done ? IDLE : READ;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      rd_data   <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      remaining <= rem_n;
      inflight  <= issue;
      if (issue) rd_data <= ram[idx];
      proto_err <= proto_err | (mem_req_valid && state != IDLE) | (mem_wr_valid && state != WRITE);
    end
  end
  always_ff @(posedge clock) begin
    if (we) ram[idx] <= mem_wr_bits;
  end
  mem_resp_fifo #(.W(MEM_DATA_BITS)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (rd_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (count)
  );
endmodule
